regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and load scoreboard for the 8 × 16-bit register file. It multiplexes the file's single write port between the ALU and memory write-back paths using valid/ready handshakes, with anti-starvation for the ALU. It tracks registers awaiting outstanding loads and drives a decode-stage stall. It sits between the execute/memory stages and the register file's DEST / w_in / w_en inputs.

## Interface
- STARVE_MAX, 3: consecutive cycles an ALU request may lose arbitration before ALU priority is forced (1–15)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU write-back request
- alu_dest  in  3  ALU destination register
- alu_data  in  16  ALU result
- alu_ready  out  1  ALU request granted this cycle (combinational)
- mem_valid  in  1  load-data write-back request
- mem_dest  in  3  load destination register
- mem_data  in  16  load data
- mem_ready  out  1  MEM request granted this cycle (combinational)
- ld_issue  in  1  load issued; marks ld_dest pending
- ld_dest  in  3  destination of issued load
- dec_src0, dec_src1, dec_dest  in  3 each  decode-stage operand/destination indices
- dec_stall  out  1  decode must hold (combinational)
- rf_wen  out  1  register-file write enable (registered)
- rf_dest  out  3  register-file write address (registered)
- rf_wdata  out  16  register-file write data (registered)
- busy  out  8  per-register pending-load bits
- err  out  1  sticky protocol-error flag

## Operation
- Two-state priority FSM: MEM_PRI (reset state) and ALU_PRI.
- MEM_PRI: mem_ready = mem_valid; alu_ready = alu_valid & ~mem_valid.
- ALU_PRI: alu_ready = alu_valid; mem_ready = mem_valid & ~alu_valid.
- Grant means valid & ready. At most one grant per cycle.
- Starve counter (4 bits) increments each cycle alu_valid & ~alu_ready.
  - Cleared on any ALU grant.
  - When it reaches STARVE_MAX: FSM moves to ALU_PRI and the counter clears.
- ALU_PRI returns to MEM_PRI after exactly one ALU grant. It holds while no ALU grant occurs.
- Granted request is latched into rf_dest/rf_wdata with rf_wen = 1. A hidden wb_is_mem flag records the source.
- With no grant, rf_wen = 0 and rf_dest/rf_wdata hold their values.
- Scoreboard:
  - busy[ld_dest] is set on ld_issue.
  - busy[rf_dest] is cleared on the edge ending a cycle with rf_wen & wb_is_mem. This is the same edge on which the register file captures the data.
  - Set and clear of the same index on the same edge: set wins.
- dec_stall = busy[dec_src0] | busy[dec_src1] | busy[dec_dest]. No forwarding is performed.
- err is set (sticky until reset) on either of:
  - an ALU grant whose alu_dest is busy;
  - a MEM grant whose mem_dest is not busy.
- Arithmetic: counter saturates at STARVE_MAX. Register indices are unsigned 3-bit, with no wrap.

## Timing
- Grant to write: request granted in cycle t → rf_wen/rf_dest/rf_wdata valid in cycle t+1 → register-file contents updated from t+2.
- ld_issue in cycle t → busy bit and dec_stall visible in t+1.
- MEM grant in t → busy bit cleared from t+2.
- ready is combinational from valid and FSM state. Requesters hold valid, dest and data stable until granted.
- Reset (asserted low, any time, asynchronous):
  - FSM = MEM_PRI, counter = 0, busy = 0, err = 0.
  - rf_wen = 0, rf_dest = 0, rf_wdata = 0.
  - An in-flight latched write is discarded. ready outputs follow their equations from reset values.
- Reset release is used synchronously to clk by the surrounding design.

## Structure
- Package regfile_pkg: NREG = 8, ADDR_W = 3, DATA_W = 16, priority-state enum {MEM_PRI, ALU_PRI}.
- Sub-module regfile_scoreboard: the busy vector with set/clear/set-wins logic and the dec_stall lookup.
- Arbiter FSM, starve counter, write latch and err flag live in the top module.

## Test plan
- Reset: hold reset = 0 with random inputs → all outputs 0 except the ready equations; release, idle 2 cycles → rf_wen stays 0.
- Single ALU write: alu_valid = 1, alu_dest = 5, alu_data = 16'hBEEF → alu_ready = 1 same cycle; next cycle rf_wen = 1, rf_dest = 5, rf_wdata = BEEF; then rf_wen = 0.
- Contention with STARVE_MAX = 3: both valid continuously → MEM granted 3 cycles, ALU granted on cycle 4, MEM on cycle 5.
- Load scoreboard:
  - ld_issue with ld_dest = 2, then dec_src1 = 2 → dec_stall = 1 from the next cycle.
  - MEM write-back with dest 2, data 16'h1234 → busy[2] clears 2 cycles after the grant, and dec_stall drops.
  - ld_issue and the MEM-write-clear both on dest 2 on the same edge → busy[2] remains 1.
- Errors:
  - ALU grant to a busy register 4 → err = 1 next cycle and stays 1.
  - MEM grant to non-busy register 6 after a fresh reset → err = 1.
- Reset mid-operation: MEM granted, then reset asserted before rf_wen's cycle ends → rf_wen = 0 immediately, busy = 0, FSM back to MEM_PRI.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizes and the write-back priority state for the register-file
// write-back arbiter and its load scoreboard.
package regfile_pkg;

  localparam int NREG   = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;

  typedef enum logic {
    MEM_PRI = 1'b0,
    ALU_PRI = 1'b1
  } pri_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set on load issue,
// cleared when the load data is written back, plus the decode stall lookup.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_idx_i,
  input  logic [ADDR_W-1:0] dec_src0_i,
  input  logic [ADDR_W-1:0] dec_src1_i,
  input  logic [ADDR_W-1:0] dec_dest_i,
  output logic [NREG-1:0]   busy_o,
  output logic              dec_stall_o
);

  logic [NREG-1:0] busy_q, busy_d;

  // The set is applied after the clear so a new load to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o      = busy_q;
  assign dec_stall_o = busy_q[dec_src0_i] | busy_q[dec_src1_i] | busy_q[dec_dest_i];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: MEM has
// priority by default, a starved ALU request forces one ALU-priority grant.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_dest_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              mem_valid_i,
  input  logic [ADDR_W-1:0] mem_dest_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              mem_ready_o,
  input  logic              ld_issue_i,
  input  logic [ADDR_W-1:0] ld_dest_i,
  input  logic [ADDR_W-1:0] dec_src0_i,
  input  logic [ADDR_W-1:0] dec_src1_i,
  input  logic [ADDR_W-1:0] dec_dest_i,
  output logic              dec_stall_o,
  output logic              rf_wen_o,
  output logic [ADDR_W-1:0] rf_dest_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [NREG-1:0]   busy_o,
  output logic              err_o
);

  pri_state_e        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              rf_wen_q, wb_is_mem_q;
  logic [ADDR_W-1:0] rf_dest_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              err_q, err_d;
  logic              alu_grant, mem_grant;
  logic [NREG-1:0]   busy;

  // Readiness follows valid and state; the starve counter promotes the ALU
  // for exactly one grant once it has lost STARVE_MAX consecutive cycles.
  always_comb begin
    alu_ready_o = 1'b0;
    mem_ready_o = 1'b0;
    state_d     = state_q;
    starve_d    = starve_q;
    unique case (state_q)
      MEM_PRI: begin
        mem_ready_o = mem_valid_i;
        alu_ready_o = alu_valid_i & ~mem_valid_i;
      end
      ALU_PRI: begin
        alu_ready_o = alu_valid_i;
        mem_ready_o = mem_valid_i & ~alu_valid_i;
      end
      default: ;
    endcase
    if (alu_valid_i & ~alu_ready_o) begin
      if (starve_q + 4'd1 >= 4'(STARVE_MAX)) begin
        state_d  = ALU_PRI;
        starve_d = 4'd0;
      end else begin
        starve_d = starve_q + 4'd1;
      end
    end
    if (alu_valid_i & alu_ready_o) begin
      starve_d = 4'd0;
      state_d  = MEM_PRI;
    end
  end

  assign alu_grant = alu_valid_i & alu_ready_o;
  assign mem_grant = mem_valid_i & mem_ready_o;
  assign err_d = err_q | (alu_grant & busy[alu_dest_i]) | (mem_grant & ~busy[mem_dest_i]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= MEM_PRI;
      starve_q <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  // Write latch: address and data hold when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_wen_q    <= 1'b0;
      wb_is_mem_q <= 1'b0;
      rf_dest_q   <= '0;
      rf_wdata_q  <= '0;
    end else if (alu_grant | mem_grant) begin
      rf_wen_q    <= 1'b1;
      wb_is_mem_q <= mem_grant;
      rf_dest_q   <= mem_grant ? mem_dest_i : alu_dest_i;
      rf_wdata_q  <= mem_grant ? mem_data_i : alu_data_i;
    end else begin
      rf_wen_q    <= 1'b0;
      wb_is_mem_q <= 1'b0;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .set_en_i    (ld_issue_i),
    .set_idx_i   (ld_dest_i),
    .clr_en_i    (rf_wen_q & wb_is_mem_q),
    .clr_idx_i   (rf_dest_q),
    .dec_src0_i  (dec_src0_i),
    .dec_src1_i  (dec_src1_i),
    .dec_dest_i  (dec_dest_i),
    .busy_o      (busy),
    .dec_stall_o (dec_stall_o)
  );

  assign busy_o     = busy;
  assign rf_wen_o   = rf_wen_q;
  assign rf_dest_o  = rf_dest_q;
  assign rf_wdata_o = rf_wdata_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change on the falling edge,
// outputs are checked 1ns later, well clear of the rising edge.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        aluValid, memValid, ldIssue;
  logic [2:0]  aluDest, memDest, ldDest, decSrc0, decSrc1, decDest;
  logic [15:0] aluData, memData;
  logic        aluReady, memReady, decStall, rfWen, err;
  logic [2:0]  rfDest;
  logic [15:0] rfWdata;
  logic [7:0]  busy;

  int vecCount = 0;
  int errCount = 0;

  regfile_wb_arbiter #(.STARVE_MAX(3)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .alu_valid_i (aluValid),
    .alu_dest_i  (aluDest),
    .alu_data_i  (aluData),
    .alu_ready_o (aluReady),
    .mem_valid_i (memValid),
    .mem_dest_i  (memDest),
    .mem_data_i  (memData),
    .mem_ready_o (memReady),
    .ld_issue_i  (ldIssue),
    .ld_dest_i   (ldDest),
    .dec_src0_i  (decSrc0),
    .dec_src1_i  (decSrc1),
    .dec_dest_i  (decDest),
    .dec_stall_o (decStall),
    .rf_wen_o    (rfWen),
    .rf_dest_o   (rfDest),
    .rf_wdata_o  (rfWdata),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [2:0] ad, input logic [15:0] adata,
                               input logic mv, input logic [2:0] md, input logic [15:0] mdata);
    aluValid = av; aluDest = ad; aluData = adata;
    memValid = mv; memDest = md; memData = mdata;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    ldIssue = 1'b0; ldDest = 3'd0;
    decSrc0 = 3'd0; decSrc1 = 3'd0; decDest = 3'd0;
  endtask

  task automatic pulseReset();
    nextCycle();
    idleInputs();
    rstN = 1'b0;
    nextCycle();
    rstN = 1'b1;
  endtask

  initial begin
    // Reset held with busy inputs: only the ready equations may be nonzero.
    rstN = 1'b0;
    applyStimulus(1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd6, 16'hAAAA);
    ldIssue = 1'b1; ldDest = 3'd3; decSrc0 = 3'd3; decSrc1 = 3'd3; decDest = 3'd3;
    nextCycle(); nextCycle(); #1;
    checkOutput("rst_rf_wen", rfWen, 0);
    checkOutput("rst_rf_dest", rfDest, 0);
    checkOutput("rst_rf_wdata", rfWdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_stall", decStall, 0);
    checkOutput("rst_mem_ready", memReady, 1);
    checkOutput("rst_alu_ready", aluReady, 0);
    nextCycle();
    idleInputs();
    rstN = 1'b1;
    nextCycle(); #1 checkOutput("idle1_wen", rfWen, 0);
    nextCycle(); #1 checkOutput("idle2_wen", rfWen, 0);

    // Single ALU write.
    nextCycle();
    applyStimulus(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 16'h0);
    #1 checkOutput("alu_ready", aluReady, 1);
    checkOutput("alu_mem_ready", memReady, 0);
    nextCycle();
    idleInputs();
    #1 checkOutput("alu_wen", rfWen, 1);
    checkOutput("alu_dest", rfDest, 5);
    checkOutput("alu_wdata", rfWdata, 16'hBEEF);
    nextCycle(); #1 checkOutput("alu_wen_drop", rfWen, 0);
    checkOutput("alu_dest_hold", rfDest, 5);
    checkOutput("alu_wdata_hold", rfWdata, 16'hBEEF);

    // Contention: MEM wins three cycles, ALU the fourth, MEM the fifth.
    nextCycle();
    applyStimulus(1'b1, 3'd1, 16'h1111, 1'b1, 3'd3, 16'h3333);
    for (int c = 1; c <= 5; c++) begin
      #1;
      checkOutput($sformatf("cont%0d_mem", c), memReady, (c == 4) ? 0 : 1);
      checkOutput($sformatf("cont%0d_alu", c), aluReady, (c == 4) ? 1 : 0);
      if (c == 5) begin
        checkOutput("cont5_wen", rfWen, 1);
        checkOutput("cont5_dest", rfDest, 1);
        checkOutput("cont5_wdata", rfWdata, 16'h1111);
      end
      nextCycle();
    end
    pulseReset();

    // Load scoreboard: issue, stall, write-back clear two cycles after grant.
    ldIssue = 1'b1; ldDest = 3'd2; decSrc1 = 3'd2;
    #1 checkOutput("ld_stall_early", decStall, 0);
    nextCycle();
    ldIssue = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h1234);
    #1 checkOutput("ld_busy", busy, 8'h04);
    checkOutput("ld_stall", decStall, 1);
    checkOutput("ld_mem_ready", memReady, 1);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    #1 checkOutput("wb_wen", rfWen, 1);
    checkOutput("wb_dest", rfDest, 2);
    checkOutput("wb_wdata", rfWdata, 16'h1234);
    checkOutput("wb_busy_still", busy, 8'h04);
    nextCycle(); #1
    checkOutput("wb_busy_clr", busy, 8'h00);
    checkOutput("wb_stall_drop", decStall, 0);
    checkOutput("wb_err", err, 0);

    // Same-edge set and clear of register 2: the set wins.
    ldIssue = 1'b1; ldDest = 3'd2;
    nextCycle();
    ldIssue = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h5678);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    ldIssue = 1'b1; ldDest = 3'd2;
    nextCycle();
    ldIssue = 1'b0;
    #1 checkOutput("setwins_busy", busy, 8'h04);
    checkOutput("setwins_err", err, 0);

    // Top register index, seen through the destination lookup.
    ldIssue = 1'b1; ldDest = 3'd7; decSrc1 = 3'd0; decDest = 3'd7;
    nextCycle();
    ldIssue = 1'b0;
    #1 checkOutput("ld7_busy", busy, 8'h84);
    checkOutput("ld7_stall", decStall, 1);
    pulseReset();

    // ALU grant to a busy register sets err, which stays set.
    ldIssue = 1'b1; ldDest = 3'd4;
    nextCycle();
    ldIssue = 1'b0;
    applyStimulus(1'b1, 3'd4, 16'h0042, 1'b0, 3'd0, 16'h0);
    #1 checkOutput("aluerr_before", err, 0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    #1 checkOutput("aluerr_set", err, 1);
    nextCycle(); nextCycle(); #1 checkOutput("aluerr_sticky", err, 1);
    pulseReset();
    #1 checkOutput("err_cleared", err, 0);

    // MEM grant to a register that is not busy.
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h0066);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    #1 checkOutput("memerr_set", err, 1);
    pulseReset();

    // Reset while a latched MEM write is being presented.
    ldIssue = 1'b1; ldDest = 3'd5;
    nextCycle();
    ldIssue = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'hABCD);
    nextCycle();
    applyStimulus(1'b1, 3'd1, 16'h0, 1'b1, 3'd5, 16'hABCD);
    #1 checkOutput("mid_wen", rfWen, 1);
    #1 rstN = 1'b0;
    #1 checkOutput("mid_rst_wen", rfWen, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_dest", rfDest, 0);
    checkOutput("mid_rst_mem_ready", memReady, 1);
    checkOutput("mid_rst_alu_ready", aluReady, 0);
    nextCycle();
    idleInputs();
    rstN = 1'b1;
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
